// File: rtl/audio_frame_minmax_ctrl_if.sv
// Sample stream and frame-result handshakes
// for the per-frame min/max controller.
interface audio_frame_minmax_ctrl_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          res_valid;
  logic [DW-1:0] res_max;
  logic [DW-1:0] res_min;
  logic [7:0]    res_frame;
  logic          res_ack;

  modport master (
    output in_valid, in_data, res_ack,
    input  in_ready, res_valid,
    input  res_max, res_min, res_frame
  );

  modport slave (
    input  in_valid, in_data, res_ack,
    output in_ready, res_valid,
    output res_max, res_min, res_frame
  );
endinterface

// File: rtl/audio_frame_minmax_ctrl.sv
// Per-frame signed min/max tracker with a
// one-deep result register and run control.
module audio_frame_minmax_ctrl #(
  parameter int FRAME_LEN = 100,
  parameter int DW        = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_frames,
  output logic       busy,
  output logic       d,
  audio_frame_minmax_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [15:0] LAST =
    16'(FRAME_LEN - 1);

  logic [1:0]  state;
  logic [7:0]  nfr;
  logic [7:0]  frame_cnt;
  logic [15:0] sample_cnt;

  logic signed [DW-1:0] smp;
  logic signed [DW-1:0] run_max;
  logic signed [DW-1:0] run_min;
  logic signed [DW-1:0] nxt_max;
  logic signed [DW-1:0] nxt_min;

  logic [DW-1:0] res_max_q;
  logic [DW-1:0] res_min_q;
  logic [7:0]    res_frame_q;
  logic          res_valid_q;

  logic first;
  logic last;
  logic blocked;
  logic acc;
  logic res_take;

  assign smp      = bus.in_data;
  assign first    = sample_cnt == 16'd0;
  assign last     = sample_cnt == LAST;
  assign res_take = res_valid_q && bus.res_ack;

  // only the frame-closing sample waits on
  // a full result register
  assign blocked = last && res_valid_q &&
                   !bus.res_ack;

  assign bus.in_ready  = (state == ACQ) &&
                         !blocked;
  assign acc           = bus.in_valid &&
                         bus.in_ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_max   = res_max_q;
  assign bus.res_min   = res_min_q;
  assign bus.res_frame = res_frame_q;
  assign busy = (state == ACQ) ||
                (state == DRAIN);

  // running extremes including the offered sample
  always_comb begin
    nxt_max = run_max;
    nxt_min = run_min;
    if (first) begin
      nxt_max = smp;
      nxt_min = smp;
    end else begin
      if (smp > run_max) nxt_max = smp;
      if (smp < run_min) nxt_min = smp;
    end
  end

  // run control, acquisition and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      nfr         <= '0;
      frame_cnt   <= '0;
      sample_cnt  <= '0;
      run_max     <= '0;
      run_min     <= '0;
      res_max_q   <= '0;
      res_min_q   <= '0;
      res_frame_q <= '0;
      res_valid_q <= 1'b0;
      d           <= 1'b0;
    end else begin
      if (res_take) res_valid_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            nfr        <= num_frames;
            frame_cnt  <= '0;
            sample_cnt <= '0;
            if (num_frames == 8'd0) begin
              state <= DONE;
              d     <= 1'b1;
            end else begin
              state <= ACQ;
              d     <= 1'b0;
            end
          end
        end
        ACQ: begin
          if (acc) begin
            run_max <= nxt_max;
            run_min <= nxt_min;
            if (last) begin
              sample_cnt  <= '0;
              res_max_q   <= nxt_max;
              res_min_q   <= nxt_min;
              res_frame_q <= frame_cnt;
              res_valid_q <= 1'b1;
              frame_cnt   <= frame_cnt + 8'd1;
              if (frame_cnt == nfr - 8'd1)
                state <= DRAIN;
            end else begin
              sample_cnt <= sample_cnt + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (res_take) begin
            state <= DONE;
            d     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_frame_minmax_ctrl.sv
// Randomized scoreboard bench for the
// per-frame min/max controller.
module tb_audio_frame_minmax_ctrl;
  localparam int FL = 100;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_frames = 8'd0;
  logic       busy;
  logic       d;

  audio_frame_minmax_ctrl_if #(.DW(DW)) bus();

  audio_frame_minmax_ctrl #(
    .FRAME_LEN(FL),
    .DW(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_frames(num_frames),
    .busy(busy),
    .d(d),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] mx;
    logic signed [31:0] mn;
    logic [7:0]         fr;
  } exp_t;

  exp_t exq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   sent = 0;
  bit   abort = 1'b0;
  int   ack_mode = 0;
  bit   ack_force = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // result consumer
  initial begin
    bus.res_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0: bus.res_ack = 1'b1;
        1: bus.res_ack = ($urandom % 3) != 0;
        default: bus.res_ack = ack_force;
      endcase
    end
  end

  // monitor: compare every consumed result
  always @(negedge clk) begin
    if (reset && bus.res_valid && bus.res_ack) begin
      if (exq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: frame %0d",
                 bus.res_frame);
      end else begin
        mon_e = exq.pop_front();
        check("res_max", bus.res_max, mon_e.mx);
        check("res_min", bus.res_min, mon_e.mn);
        check("res_frame", {24'd0, bus.res_frame},
              {24'd0, mon_e.fr});
      end
    end
  end

  function automatic logic signed [31:0] gen(
    input int pat, input int f, input int j);
    int t;
    case (pat)
      0: return j;
      1: begin
        if (f == 0) return (j % 2) ? 100 : -100;
        return 42;
      end
      2: return $urandom;
      default: begin
        if (j == 10) return 32'sh8000_0000;
        if (j == 60) return 32'sh7fff_ffff;
        t = int'($urandom_range(0, 2000)) - 1000;
        return t;
      end
    endcase
  endfunction

  task automatic run(input int n, input int pat,
                     input bit ign);
    logic signed [31:0] s[$];
    logic signed [31:0] mx;
    logic signed [31:0] mn;
    int to;
    bit acc;
    for (int f = 0; f < n; f++) begin
      for (int j = 0; j < FL; j++)
        s.push_back(gen(pat, f, j));
      mx = s[f*FL];
      mn = s[f*FL];
      for (int j = 1; j < FL; j++) begin
        if (s[f*FL+j] > mx) mx = s[f*FL+j];
        if (s[f*FL+j] < mn) mn = s[f*FL+j];
      end
      exq.push_back('{mx, mn, 8'(f)});
    end
    sent = 0;
    start = 1'b1;
    num_frames = 8'(n);
    tick;
    start = 1'b0;
    for (int i = 0; i < n * FL; i++) begin
      if (ign && i == 37) begin
        bus.in_valid = 1'b0;
        start = 1'b1;
        num_frames = 8'd0;
        tick;
        start = 1'b0;
      end
      if ($urandom % 4 == 0) begin
        bus.in_valid = 1'b0;
        tick;
      end
      bus.in_valid = 1'b1;
      bus.in_data = s[i];
      to = 0;
      acc = 1'b0;
      while (!acc && to < 3000 && !abort) begin
        @(negedge clk);
        acc = bus.in_ready;
        tick;
        to++;
      end
      if (abort) begin
        bus.in_valid = 1'b0;
        return;
      end
      if (!acc) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: sample %0d", i);
        bus.in_valid = 1'b0;
        return;
      end
      sent++;
    end
    bus.in_valid = 1'b0;
    to = 0;
    while (!d && to < 3000) begin
      @(negedge clk);
      to++;
    end
    check("done_d", {31'd0, d}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("queue_empty", exq.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int to;
    int cnt;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) tick;
    check("rst_in_ready", {31'd0, bus.in_ready}, 0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_d", {31'd0, d}, 0);
    check("rst_res_max", bus.res_max, 0);
    check("rst_res_min", bus.res_min, 0);
    check("rst_res_frame", {24'd0, bus.res_frame}, 0);
    reset = 1'b1;
    tick;

    ack_mode = 0;
    run(1, 0, 1'b0);
    run(2, 1, 1'b0);

    ack_mode = 2;
    ack_force = 1'b0;
    tick;
    fork
      run(3, 2, 1'b0);
      begin
        to = 0;
        while (!(sent == 199 && bus.in_valid) &&
               to < 5000) begin
          @(negedge clk);
          to++;
        end
        check("bp_reached", {31'd0, to < 5000}, 1);
        repeat (3) @(negedge clk);
        check("bp_in_ready", {31'd0, bus.in_ready}, 0);
        check("bp_held_frame",
              {24'd0, bus.res_frame}, 0);
        check("bp_sent", sent, 199);
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        @(negedge clk);
        check("nobubble_valid",
              {31'd0, bus.res_valid}, 1);
        check("nobubble_frame",
              {24'd0, bus.res_frame}, 1);
        check("nobubble_sent", sent, 200);
        repeat (5) @(negedge clk);
        ack_mode = 1;
      end
    join

    ack_mode = 1;
    run(5, 2, 1'b1);
    run(2, 3, 1'b0);

    tick;
    start = 1'b1;
    num_frames = 8'd0;
    tick;
    start = 1'b0;
    check("zero_d", {31'd0, d}, 1);
    check("zero_busy", {31'd0, busy}, 0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.res_valid) cnt++;
    end
    check("zero_no_result", cnt, 0);
    tick;

    fork
      run(2, 2, 1'b0);
      begin
        to = 0;
        while (sent != 50 && to < 5000) begin
          @(negedge clk);
          to++;
        end
        check("mid_reached", {31'd0, to < 5000}, 1);
        reset = 1'b0;
        abort = 1'b1;
        exq.delete();
        #1;
        check("mid_in_ready", {31'd0, bus.in_ready}, 0);
        check("mid_res_valid",
              {31'd0, bus.res_valid}, 0);
        check("mid_busy", {31'd0, busy}, 0);
        check("mid_d", {31'd0, d}, 0);
        check("mid_res_max", bus.res_max, 0);
        check("mid_res_min", bus.res_min, 0);
        check("mid_res_frame",
              {24'd0, bus.res_frame}, 0);
      end
    join
    bus.in_valid = 1'b0;
    tick;
    reset = 1'b1;
    abort = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.res_valid) cnt++;
    end
    check("post_rst_no_result", cnt, 0);
    check("post_rst_busy", {31'd0, busy}, 0);
    tick;
    run(1, 2, 1'b0);

    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
